// File: rtl/draw_pkg.sv
// Shared types and width helpers for the rectangle drawing pipeline.
package draw_pkg;

  // Default framebuffer coordinate width and its one-bit-wider companion,
  // used for inner-bound arithmetic that must never wrap.
  localparam int CORDW_DEF = 16;
  localparam int CORDW_EXT = CORDW_DEF + 1;

  typedef enum logic {
    MODE_OUTLINE = 1'b0,
    MODE_FILL    = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } rect_state_t;

  // Extended width for a given coordinate width.
  function automatic int ext_w(input int cordw);
    return cordw + 1;
  endfunction

endpackage

// File: rtl/rect_row_span.sv
// Per-row span helper: decides whether the current row crosses the hollow
// interior of an outline rectangle and where the scan jumps over it.
module rect_row_span
  import draw_pkg::*;
#(
  parameter int CORDW = CORDW_DEF,
  parameter int EW    = CORDW_EXT
) (
  input  logic [CORDW-1:0] y,
  input  logic [EW-1:0]    ixl,
  input  logic [EW-1:0]    ixr,
  input  logic [EW-1:0]    iyt,
  input  logic [EW-1:0]    iyb,
  input  mode_t            mode,
  output logic             row_interior,
  output logic [CORDW-1:0] skip_from,
  output logic [CORDW-1:0] skip_to
);

  logic [EW-1:0] y_ext;

  // Interior exists only in outline mode with a non-empty inner box; the
  // skip points are only meaningful when row_interior is high, in which
  // case ixl-1 >= xa and ixr+1 <= xb, so both fit the coordinate width.
  always_comb begin
    y_ext        = {1'b0, y};
    row_interior = (mode == MODE_OUTLINE) &&
                   (ixl <= ixr) && (iyt <= iyb) &&
                   (y_ext >= iyt) && (y_ext <= iyb);
    skip_from    = ixl[CORDW-1:0] - CORDW'(1);
    skip_to      = ixr[CORDW-1:0] + CORDW'(1);
  end

endmodule

// File: rtl/draw_rectangle_ext.sv
// Rectangle rasteriser: emits one pixel per enabled cycle, row-major, for a
// filled rectangle or a bordered outline of programmable thickness.
module draw_rectangle_ext
  import draw_pkg::*;
#(
  parameter int CORDW = CORDW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             oe,
  input  logic             mode,
  input  logic [CORDW-1:0] thick,
  input  logic [CORDW-1:0] x0,
  input  logic [CORDW-1:0] y0,
  input  logic [CORDW-1:0] x1,
  input  logic [CORDW-1:0] y1,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic             drawing,
  output logic             busy,
  output logic             done
);

  localparam int EW = ext_w(CORDW);

  rect_state_t      state_reg, state_next;
  mode_t            mode_reg, mode_next;
  logic [CORDW-1:0] te_reg, te_next;
  logic [CORDW-1:0] xa_reg, xa_next, xb_reg, xb_next;
  logic [CORDW-1:0] ya_reg, ya_next, yb_reg, yb_next;
  logic [EW-1:0]    ixl_reg, ixl_next, ixr_reg, ixr_next;
  logic [EW-1:0]    iyt_reg, iyt_next, iyb_reg, iyb_next;
  logic [CORDW-1:0] cx_reg, cx_next, cy_reg, cy_next;
  logic [CORDW-1:0] x_reg, x_next, y_reg, y_next;
  logic             drawing_reg, drawing_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             row_interior;
  logic [CORDW-1:0] skip_from, skip_to;
  logic [EW-1:0]    xa_e, xb_e, ya_e, yb_e, te_e;
  logic [EW-1:0]    ixl_calc, ixr_calc, iyt_calc, iyb_calc;

  rect_row_span #(
    .CORDW (CORDW),
    .EW    (EW)
  ) u_span (
    .y            (cy_reg),
    .ixl          (ixl_reg),
    .ixr          (ixr_reg),
    .iyt          (iyt_reg),
    .iyb          (iyb_reg),
    .mode         (mode_reg),
    .row_interior (row_interior),
    .skip_from    (skip_from),
    .skip_to      (skip_to)
  );

  // Inner bounds in extended width; a right/bottom bound that would go
  // negative clamps to 0, which is always below the left/top bound (>= 1)
  // and therefore yields an empty interior instead of a wrapped one.
  always_comb begin
    xa_e     = {1'b0, xa_reg};
    xb_e     = {1'b0, xb_reg};
    ya_e     = {1'b0, ya_reg};
    yb_e     = {1'b0, yb_reg};
    te_e     = {1'b0, te_reg};
    ixl_calc = xa_e + te_e;
    iyt_calc = ya_e + te_e;
    ixr_calc = (xb_e < te_e) ? '0 : (xb_e - te_e);
    iyb_calc = (yb_e < te_e) ? '0 : (yb_e - te_e);
  end

  // Next-state and next-output logic for the scan FSM.
  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    te_next      = te_reg;
    xa_next      = xa_reg;
    xb_next      = xb_reg;
    ya_next      = ya_reg;
    yb_next      = yb_reg;
    ixl_next     = ixl_reg;
    ixr_next     = ixr_reg;
    iyt_next     = iyt_reg;
    iyb_next     = iyb_reg;
    cx_next      = cx_reg;
    cy_next      = cy_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    drawing_next = 1'b0;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_INIT;
          busy_next  = 1'b1;
          mode_next  = mode_t'(mode);
          te_next    = (thick == '0) ? CORDW'(1) : thick;
          xa_next    = (x0 < x1) ? x0 : x1;
          xb_next    = (x0 < x1) ? x1 : x0;
          ya_next    = (y0 < y1) ? y0 : y1;
          yb_next    = (y0 < y1) ? y1 : y0;
        end
      end

      ST_INIT: begin
        ixl_next   = ixl_calc;
        ixr_next   = ixr_calc;
        iyt_next   = iyt_calc;
        iyb_next   = iyb_calc;
        cx_next    = xa_reg;
        cy_next    = ya_reg;
        state_next = ST_DRAW;
      end

      ST_DRAW: begin
        if (oe) begin
          drawing_next = 1'b1;
          x_next       = cx_reg;
          y_next       = cy_reg;
          if ((cx_reg == xb_reg) && (cy_reg == yb_reg)) begin
            state_next = ST_DONE;
          end else if (row_interior && (cx_reg == skip_from)) begin
            cx_next = skip_to;
          end else if (cx_reg == xb_reg) begin
            cx_next = xa_reg;
            cy_next = cy_reg + CORDW'(1);
          end else begin
            cx_next = cx_reg + CORDW'(1);
          end
        end
      end

      ST_DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, latched geometry and registered outputs; reset abandons any shape.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      mode_reg    <= MODE_OUTLINE;
      te_reg      <= '0;
      xa_reg      <= '0;
      xb_reg      <= '0;
      ya_reg      <= '0;
      yb_reg      <= '0;
      ixl_reg     <= '0;
      ixr_reg     <= '0;
      iyt_reg     <= '0;
      iyb_reg     <= '0;
      cx_reg      <= '0;
      cy_reg      <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      drawing_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      te_reg      <= te_next;
      xa_reg      <= xa_next;
      xb_reg      <= xb_next;
      ya_reg      <= ya_next;
      yb_reg      <= yb_next;
      ixl_reg     <= ixl_next;
      ixr_reg     <= ixr_next;
      iyt_reg     <= iyt_next;
      iyb_reg     <= iyb_next;
      cx_reg      <= cx_next;
      cy_reg      <= cy_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      drawing_reg <= drawing_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign x       = x_reg;
  assign y       = y_reg;
  assign drawing = drawing_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_draw_rectangle_ext.sv
// Directed bench for draw_rectangle_ext: one task per scenario.
module tb_draw_rectangle_ext;
  import draw_pkg::*;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          oe = 1'b0;
  logic          mode = 1'b0;
  logic [CW-1:0] thick = '0;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [CW-1:0] x, y;
  logic          drawing, busy, done;

  int total = 0;
  int bad = 0;

  int px[$], py[$], pc[$];
  int ex[$], ey[$];
  int done_at, busy_init, busy_at_done, hold_bad;

  draw_rectangle_ext #(.CORDW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .oe      (oe),
    .mode    (mode),
    .thick   (thick),
    .x0      (x0),
    .y0      (y0),
    .x1      (x1),
    .y1      (y1),
    .x       (x),
    .y       (y),
    .drawing (drawing),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one shape and record every emitted pixel with its cycle index
  // (cycle 0 = just after the edge that accepted start).
  task automatic run_shape(input logic m, input int t, input int ax0, input int ay0,
                           input int ax1, input int ay1, input logic [3:0] oe_pat,
                           input int pulse_at);
    int c;
    int lx, ly;
    logic oe_prev;
    px.delete(); py.delete(); pc.delete();
    done_at = -1; busy_init = 0; busy_at_done = 1; hold_bad = 0;
    mode = m; thick = CW'(t);
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    oe = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    lx = int'(x); ly = int'(y);
    while (c < 300 && done_at < 0) begin
      oe = oe_pat[c % 4];
      start = (c == pulse_at);
      oe_prev = oe;
      step();
      c++;
      if (c == 1) busy_init = int'(busy);
      if (drawing) begin
        px.push_back(int'(x)); py.push_back(int'(y)); pc.push_back(c);
      end
      if (!oe_prev && (drawing || int'(x) != lx || int'(y) != ly)) hold_bad++;
      lx = int'(x); ly = int'(y);
      if (done) begin
        done_at = c;
        busy_at_done = int'(busy);
      end
    end
    start = 1'b0;
    oe = 1'b1;
  endtask

  // Reference pixel set by direct membership test over the bounding box.
  task automatic build_ref(input logic m, input int t, input int ax0, input int ay0,
                           input int ax1, input int ay1);
    int xa, xb, ya, yb, te;
    logic inner;
    xa = (ax0 < ax1) ? ax0 : ax1; xb = (ax0 < ax1) ? ax1 : ax0;
    ya = (ay0 < ay1) ? ay0 : ay1; yb = (ay0 < ay1) ? ay1 : ay0;
    te = (t == 0) ? 1 : t;
    ex.delete(); ey.delete();
    for (int yy = ya; yy <= yb; yy++) begin
      for (int xx = xa; xx <= xb; xx++) begin
        inner = (m == 1'b0) && (xx >= xa + te) && (xx <= xb - te) &&
                (yy >= ya + te) && (yy <= yb - te);
        if (!inner) begin
          ex.push_back(xx); ey.push_back(yy);
        end
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    step(); step();
    total++; if (x !== '0) begin bad++; $display("FAIL reset_x: got %0d want 0", x); end
    total++; if (y !== '0) begin bad++; $display("FAIL reset_y: got %0d want 0", y); end
    total++; if (drawing !== 1'b0) begin bad++; $display("FAIL reset_drawing: got %b want 0", drawing); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill_basic();
    int exp_x[6] = '{2, 3, 4, 2, 3, 4};
    int exp_y[6] = '{3, 3, 3, 4, 4, 4};
    run_shape(1'b1, 0, 4, 4, 2, 3, 4'b1111, -1);
    $display("fill_basic: pixels=%0d done_at=%0d", px.size(), done_at);
    total++; if (px.size() != 6) begin bad++; $display("FAIL fill_count: got %0d want 6", px.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= px.size()) begin
        bad++; $display("FAIL fill_px%0d: got none want (%0d,%0d)", i, exp_x[i], exp_y[i]);
      end else if (px[i] != exp_x[i] || py[i] != exp_y[i] || pc[i] != i + 2) begin
        bad++; $display("FAIL fill_px%0d: got (%0d,%0d)@%0d want (%0d,%0d)@%0d",
                        i, px[i], py[i], pc[i], exp_x[i], exp_y[i], i + 2);
      end
    end
    total++; if (done_at != 8) begin bad++; $display("FAIL fill_done_cycle: got %0d want 8", done_at); end
    total++; if (busy_init != 1) begin bad++; $display("FAIL fill_busy_init: got %0d want 1", busy_init); end
    total++; if (busy_at_done != 0) begin bad++; $display("FAIL fill_busy_done: got %0d want 0", busy_at_done); end
  endtask

  task automatic test_outline_t1();
    int hits;
    int idx;
    run_shape(1'b0, 1, 0, 0, 3, 3, 4'b1111, -1);
    build_ref(1'b0, 1, 0, 0, 3, 3);
    $display("outline_t1: pixels=%0d done_at=%0d", px.size(), done_at);
    total++; if (px.size() != 12) begin bad++; $display("FAIL ot1_count: got %0d want 12", px.size()); end
    for (int i = 0; i < ex.size() && i < px.size(); i++) begin
      total++;
      if (px[i] != ex[i] || py[i] != ey[i]) begin
        bad++; $display("FAIL ot1_px%0d: got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
      end
    end
    hits = 0; idx = -1;
    for (int i = 0; i < px.size(); i++) begin
      if (px[i] >= 1 && px[i] <= 2 && py[i] >= 1 && py[i] <= 2) hits++;
      if (px[i] == 0 && py[i] == 1) idx = i;
    end
    total++; if (hits != 0) begin bad++; $display("FAIL ot1_interior: got %0d interior pixels want 0", hits); end
    total++;
    if (idx < 0 || idx + 1 >= px.size()) begin
      bad++; $display("FAIL ot1_skip: pixel (0,1) or its successor missing");
    end else if (px[idx+1] != 3 || py[idx+1] != 1 || pc[idx+1] - pc[idx] != 1) begin
      bad++; $display("FAIL ot1_skip: got (%0d,%0d) after %0d cycles want (3,1) after 1",
                      px[idx+1], py[idx+1], pc[idx+1] - pc[idx]);
    end
    total++; if (done_at != 14) begin bad++; $display("FAIL ot1_done_cycle: got %0d want 14", done_at); end
  endtask

  task automatic test_outline_t2_t0();
    int hole;
    run_shape(1'b0, 2, 0, 0, 4, 4, 4'b1111, -1);
    build_ref(1'b0, 2, 0, 0, 4, 4);
    $display("outline_t2: pixels=%0d", px.size());
    total++; if (px.size() != 24) begin bad++; $display("FAIL ot2_count: got %0d want 24", px.size()); end
    hole = 0;
    for (int i = 0; i < px.size(); i++) if (px[i] == 2 && py[i] == 2) hole++;
    total++; if (hole != 0) begin bad++; $display("FAIL ot2_hole: got %0d copies of (2,2) want 0", hole); end
    for (int i = 0; i < ex.size() && i < px.size(); i++) begin
      total++;
      if (px[i] != ex[i] || py[i] != ey[i]) begin
        bad++; $display("FAIL ot2_px%0d: got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
      end
    end
    run_shape(1'b0, 0, 4, 4, 0, 0, 4'b1111, -1);
    build_ref(1'b0, 0, 4, 4, 0, 0);
    $display("outline_t0: pixels=%0d", px.size());
    total++; if (px.size() != 16) begin bad++; $display("FAIL ot0_count: got %0d want 16", px.size()); end
    for (int i = 0; i < ex.size() && i < px.size(); i++) begin
      total++;
      if (px[i] != ex[i] || py[i] != ey[i]) begin
        bad++; $display("FAIL ot0_px%0d: got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_thick_border();
    int ox[$], oy[$];
    run_shape(1'b0, 5, 10, 10, 13, 12, 4'b1111, -1);
    ox = px; oy = py;
    run_shape(1'b1, 0, 13, 12, 10, 10, 4'b1111, -1);
    $display("thick_border: outline=%0d fill=%0d", ox.size(), px.size());
    total++; if (ox.size() != 12) begin bad++; $display("FAIL thick_count: got %0d want 12", ox.size()); end
    total++; if (px.size() != 12) begin bad++; $display("FAIL thick_fill_count: got %0d want 12", px.size()); end
    for (int i = 0; i < 12 && i < ox.size(); i++) begin
      total++;
      if (ox[i] != 10 + (i % 4) || oy[i] != 10 + (i / 4)) begin
        bad++; $display("FAIL thick_px%0d: got (%0d,%0d) want (%0d,%0d)", i, ox[i], oy[i], 10 + (i % 4), 10 + (i / 4));
      end
    end
    for (int i = 0; i < 12 && i < px.size(); i++) begin
      total++;
      if (px[i] != 10 + (i % 4) || py[i] != 10 + (i / 4)) begin
        bad++; $display("FAIL thick_fill_px%0d: got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], 10 + (i % 4), 10 + (i / 4));
      end
    end
  endtask

  task automatic test_single_pixel();
    for (int m = 0; m < 2; m++) begin
      run_shape(m[0], 3, 7, 7, 7, 7, 4'b1111, -1);
      $display("single_pixel mode=%0d: pixels=%0d done_at=%0d", m, px.size(), done_at);
      total++; if (px.size() != 1) begin bad++; $display("FAIL single_count_m%0d: got %0d want 1", m, px.size()); end
      total++;
      if (px.size() < 1 || px[0] != 7 || py[0] != 7) begin
        bad++; $display("FAIL single_px_m%0d: got %0d pixels want (7,7)", m, px.size());
      end
      total++; if (done_at != 3) begin bad++; $display("FAIL single_done_m%0d: got %0d want 3", m, done_at); end
    end
  endtask

  task automatic test_oe_stall();
    run_shape(1'b1, 0, 0, 0, 2, 1, 4'b1001, 4);
    build_ref(1'b1, 0, 0, 0, 2, 1);
    $display("oe_stall: pixels=%0d hold_bad=%0d done_at=%0d", px.size(), hold_bad, done_at);
    total++; if (px.size() != 6) begin bad++; $display("FAIL stall_count: got %0d want 6", px.size()); end
    for (int i = 0; i < ex.size() && i < px.size(); i++) begin
      total++;
      if (px[i] != ex[i] || py[i] != ey[i]) begin
        bad++; $display("FAIL stall_px%0d: got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
      end
    end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL stall_hold: got %0d moving stalled cycles want 0", hold_bad); end
    step(); step();
    total++;
    if (busy !== 1'b0 || drawing !== 1'b0) begin
      bad++; $display("FAIL stall_no_requeue: got busy=%b drawing=%b want 0 0", busy, drawing);
    end
  endtask

  task automatic test_reset_mid_draw();
    int seen;
    int n;
    mode = 1'b1; thick = '0; x0 = '0; y0 = '0; x1 = CW'(3); y1 = CW'(3);
    oe = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    seen = 0; n = 0;
    while (seen < 3 && n < 20) begin
      step(); n++;
      if (drawing) seen++;
    end
    rst_n = 1'b0;
    #1;
    $display("reset_mid_draw: after %0d pixels x=%0d y=%0d drawing=%b busy=%b", seen, x, y, drawing, busy);
    total++; if (seen != 3) begin bad++; $display("FAIL rmd_pixels_before: got %0d want 3", seen); end
    total++;
    if (x !== '0 || y !== '0 || drawing !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rmd_outputs: got x=%0d y=%0d d=%b b=%b dn=%b want all 0", x, y, drawing, busy, done);
    end
    total++;
    if (dut.state_reg !== ST_IDLE) begin
      bad++; $display("FAIL rmd_state: got %0d want %0d", dut.state_reg, ST_IDLE);
    end
    step();
    rst_n = 1'b1;
    step();
    run_shape(1'b1, 0, 5, 5, 6, 6, 4'b1111, -1);
    build_ref(1'b1, 0, 5, 5, 6, 6);
    $display("reset_mid_draw: fresh shape pixels=%0d done_at=%0d", px.size(), done_at);
    total++; if (px.size() != 4) begin bad++; $display("FAIL rmd_fresh_count: got %0d want 4", px.size()); end
    for (int i = 0; i < ex.size() && i < px.size(); i++) begin
      total++;
      if (px[i] != ex[i] || py[i] != ey[i]) begin
        bad++; $display("FAIL rmd_fresh_px%0d: got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
      end
    end
    total++; if (done_at != 6) begin bad++; $display("FAIL rmd_fresh_done: got %0d want 6", done_at); end
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_outline_t1();
    test_outline_t2_t0();
    test_thick_border();
    test_single_pixel();
    test_oe_stall();
    test_reset_mid_draw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/draw_rectangle_ext.md
# draw_rectangle_ext

Parametrised rectangle rasteriser for the framebuffer drawing pipeline. Emits one pixel coordinate per enabled cycle, row-major, for a filled or bordered rectangle with programmable border thickness. Arbitrary corner ordering is accepted. Sits between the shape sequencer and the framebuffer write port, in the same slot as the outline-only rectangle drawer it supersedes.

## Interface
- `CORDW`, default 16: framebuffer coordinate width in bits.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin drawing; sampled only in IDLE.
- `oe`  in  1  output enable; low stalls the scan, holding `x`/`y`.
- `mode`  in  1  `MODE_OUTLINE`=0, `MODE_FILL`=1; latched at start.
- `thick`  in  CORDW  border thickness T in OUTLINE; 0 treated as 1; latched at start.
- `x0`, `y0`, `x1`, `y1`  in  CORDW each  opposite corners, any order; latched at start.
- `x`, `y`  out  CORDW each  current pixel position.
- `drawing`  out  1  `x`/`y` is a valid pixel this cycle.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse after the last pixel.

## Operation
- States: IDLE, INIT, DRAW, DONE.
- IDLE with `start`=1 → INIT: latch inputs, set `busy`.
- INIT (1 cycle) computes the bounds and the first row, then goes to DRAW.
  - xa=min(x0,x1), xb=max(x0,x1); ya, yb likewise.
  - Te = max(T,1).
  - Inner bounds: ixl=xa+Te, ixr=xb-Te, iyt=ya+Te, iyb=yb-Te, computed at CORDW+1 bits with underflow clamped. No wrap is permitted.
- Pixel set:
  - FILL: every (x,y) with xa≤x≤xb and ya≤y≤yb.
  - OUTLINE: the same set minus the interior ixl≤x≤ixr, iyt≤y≤iyb. The interior is empty when ixl>ixr or iyt>iyb.
- Scan order: y ascending from ya; x ascending within each row.
- Interior skip: on an interior row, the pixel after x=ixl-1 is x=ixr+1 in the next enabled cycle, with no bubble.
- DRAW with `oe`=1: `drawing`=1, and the scan advances one pixel per cycle.
- DRAW with `oe`=0: `drawing`=0, `x`/`y` held, no advance.
- Last pixel is (xb,yb). On the enabled cycle that emits it, go to DONE.
- DONE (1 cycle): `done`=1, `busy`=0, `drawing`=0, then IDLE.
- `start` while busy is ignored; no queueing.
- Degenerate shapes are legal and emit each pixel exactly once:
  - xa=xb and/or ya=yb (single row, column or pixel).
  - T ≥ half the width or height (border covers everything, identical to FILL).
- Reset (`rst_n`=0) at any time, including mid-DRAW:
  - immediately returns to IDLE.
  - drives `x`=0, `y`=0, `drawing`=0, `busy`=0, `done`=0.
  - abandons the in-progress shape.

## Timing
- Reset values: `x`=0, `y`=0, `drawing`=0, `busy`=0, `done`=0, state IDLE.
- `start` high at edge k:
  - INIT at k+1.
  - First pixel, if `oe`=1, valid in the cycle after edge k+2.
- With `oe` held high, N pixels take cycles k+2 .. k+N+1; `done` is high in the cycle after edge k+N+2.
- FILL: N = (xb-xa+1)(yb-ya+1).
- OUTLINE: N = FILL count minus interior area.
- `x`, `y`, `drawing`, `done` are registered outputs; no combinational path from inputs.
- A new `start` is accepted in the cycle `done` is high only after IDLE is re-entered, so the minimum gap between shapes is 1 idle cycle.

## Structure
- Shared package `draw_pkg`:
  - `mode_t` enum (`MODE_OUTLINE`, `MODE_FILL`).
  - State enum `rect_state_t`.
  - Localparam for the extended width CORDW+1.
- Sub-module `rect_row_span` (combinational): given y, the latched bounds and the mode, returns row-is-interior, skip-from and skip-to. The main module holds the FSM, latched bounds and x/y counters.

## Test plan
- FILL, (x0,y0)=(4,4), (x1,y1)=(2,3), `oe`=1 → 6 pixels in order (2,3)(3,3)(4,3)(2,4)(3,4)(4,4); `done` 1 cycle after (4,4); total 9 cycles from start.
- OUTLINE, T=1, (0,0)-(3,3) → 12 pixels. Rows 1 and 2 emit only x=0,3, back-to-back cycles. No interior pixel appears.
- OUTLINE, T=2, (0,0)-(4,4) → 24 pixels; only (2,2) omitted. T=0 on the same box → 16 pixels (treated as T=1).
- OUTLINE, T=5 on (10,10)-(13,12) → same 12-pixel sequence as FILL. Single pixel (7,7) in either mode → 1 pixel, then `done`.
- FILL 3×2 with `oe` toggled 1,0,0,1,… → sequence unchanged, `x`/`y` held while `oe`=0. `start` pulsed mid-draw is ignored.
- Assert `rst_n`=0 after the 3rd pixel of a 4×4 fill → outputs zero and state IDLE with no clock edge needed. A fresh start afterwards draws the full new shape.
